// File: rtl/sprite_compositor_pkg.sv
// Shared constants and types for the sprite compositor.
package sprite_compositor_pkg;

    // Pixel format is RRRGGGBB.
    localparam int PIX_W = 8;

    // Colour driven outside active video and out of reset.
    localparam logic [PIX_W-1:0] PIX_BLACK = 8'h00;

    // Suggested background colour for integrators that have no palette yet.
    localparam logic [PIX_W-1:0] BG_DEFAULT = 8'h00;

    // Collision snapshot handshake: IDLE means no unread snapshot.
    typedef enum logic [0:0] {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_e;

endpackage

// File: rtl/sprite_compositor_prio_encoder.sv
// Lowest-index-wins priority encoder used to pick the winning sprite.
module prio_encoder #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Scan from the top down so the lowest set index is the last to land.
    always_comb begin
        idx_o = {IDX_W{1'b0}};
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end else begin
                idx_o = idx_o;
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel sprite arbiter: picks the highest-priority drawing sprite,
// falls back to the background colour, and reports per-frame sprite
// overlaps to game logic through a valid/ack handshake.
module sprite_compositor #(
    parameter int NUM_SPR = 4,
    parameter int PIX_W   = sprite_compositor_pkg::PIX_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pix_en,
    input  logic                                   data_enable,
    input  logic                                   frame,
    input  logic [NUM_SPR-1:0]                     spr_draw,
    input  logic [NUM_SPR*PIX_W-1:0]               spr_pixel,
    input  logic [NUM_SPR-1:0]                     spr_en,
    input  logic [PIX_W-1:0]                       bg_color,
    output logic [PIX_W-1:0]                       vga_out,
    output logic [((NUM_SPR > 1) ? $clog2(NUM_SPR) : 1)-1:0] win_id,
    output logic                                   win_valid,
    output logic [NUM_SPR-1:0]                     coll_status,
    output logic                                   coll_valid,
    input  logic                                   coll_ack,
    output logic                                   coll_overrun
);

    import sprite_compositor_pkg::*;

    localparam int IDX_W = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;

    // Requests and collision contribution for the current pixel
    logic [NUM_SPR-1:0] req_s;
    logic [NUM_SPR-1:0] contrib_s;
    logic               frame_evt_s;

    // Winner selection
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_any_s;
    logic [PIX_W-1:0]   win_pixel_s;

    // Compositing registers
    logic [PIX_W-1:0]   vga_d,       vga_q;
    logic [IDX_W-1:0]   win_id_d,    win_id_q;
    logic               win_valid_d, win_valid_q;

    // Collision registers
    logic [NUM_SPR-1:0] acc_d,       acc_q;
    logic [NUM_SPR-1:0] status_d,    status_q;
    logic               overrun_d,   overrun_q;

    // Handshake state
    hs_state_e          hs_d,        hs_q;

    // Masked requests; an overlap is two or more simultaneous requests in active video.
    always_comb begin
        req_s       = spr_draw & spr_en;
        frame_evt_s = pix_en & frame;
        if (data_enable && ((req_s & (req_s - NUM_SPR'(1))) != {NUM_SPR{1'b0}})) begin
            contrib_s = req_s;
        end else begin
            contrib_s = {NUM_SPR{1'b0}};
        end
    end

    prio_encoder #(
        .N     (NUM_SPR),
        .IDX_W (IDX_W)
    ) u_prio (
        .req_i (req_s),
        .idx_o (win_idx_s),
        .any_o (win_any_s)
    );

    // Fetch the colour of the winning sprite from the packed bus.
    always_comb begin
        win_pixel_s = spr_pixel[win_idx_s*PIX_W +: PIX_W];
    end

    // Next composited pixel: black in blanking, background when nobody draws.
    always_comb begin
        vga_d       = vga_q;
        win_id_d    = win_id_q;
        win_valid_d = win_valid_q;
        if (pix_en) begin
            if (!data_enable) begin
                vga_d       = PIX_W'(PIX_BLACK);
                win_id_d    = {IDX_W{1'b0}};
                win_valid_d = 1'b0;
            end else if (!win_any_s) begin
                vga_d       = bg_color;
                win_id_d    = {IDX_W{1'b0}};
                win_valid_d = 1'b0;
            end else begin
                vga_d       = win_pixel_s;
                win_id_d    = win_idx_s;
                win_valid_d = 1'b1;
            end
        end else begin
            vga_d       = vga_q;
            win_id_d    = win_id_q;
            win_valid_d = win_valid_q;
        end
    end

    // Compositing output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_q       <= PIX_W'(PIX_BLACK);
            win_id_q    <= {IDX_W{1'b0}};
            win_valid_q <= 1'b0;
        end else begin
            vga_q       <= vga_d;
            win_id_q    <= win_id_d;
            win_valid_q <= win_valid_d;
        end
    end

    // Collision accumulation and frame snapshot; the frame pixel's overlap
    // belongs to the closing frame, never to the new one.
    always_comb begin
        acc_d     = acc_q;
        status_d  = status_q;
        overrun_d = overrun_q;
        if (frame_evt_s) begin
            status_d = acc_q | contrib_s;
            acc_d    = {NUM_SPR{1'b0}};
            if ((hs_q == HS_PENDING) && !coll_ack) begin
                overrun_d = 1'b1;
            end else begin
                overrun_d = overrun_q;
            end
        end else if (pix_en) begin
            acc_d = acc_q | contrib_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Collision registers; reset also drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= {NUM_SPR{1'b0}};
            status_q  <= {NUM_SPR{1'b0}};
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            status_q  <= status_d;
            overrun_q <= overrun_d;
        end
    end

    // Handshake next state; a new snapshot outranks a same-cycle ack.
    always_comb begin
        hs_d = hs_q;
        case (hs_q)
            HS_IDLE: begin
                if (frame_evt_s) begin
                    hs_d = HS_PENDING;
                end else begin
                    hs_d = HS_IDLE;
                end
            end
            HS_PENDING: begin
                if (frame_evt_s) begin
                    hs_d = HS_PENDING;
                end else if (coll_ack) begin
                    hs_d = HS_IDLE;
                end else begin
                    hs_d = HS_PENDING;
                end
            end
            default: begin
                hs_d = HS_IDLE;
            end
        endcase
    end

    // Handshake state register; acks are honoured regardless of pix_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= HS_IDLE;
        end else begin
            hs_q <= hs_d;
        end
    end

    assign vga_out      = vga_q;
    assign win_id       = win_id_q;
    assign win_valid    = win_valid_q;
    assign coll_status  = status_q;
    assign coll_valid   = (hs_q == HS_PENDING);
    assign coll_overrun = overrun_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_sprite_compositor;

    localparam int N  = 4;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rst, pix_en, data_enable, frame, coll_ack;
    logic [N-1:0]    spr_draw, spr_en;
    logic [N*PW-1:0] spr_pixel;
    logic [PW-1:0]   bg_color;
    logic [PW-1:0]   vga_out;
    logic [1:0]      win_id;
    logic            win_valid, coll_valid, coll_overrun;
    logic [N-1:0]    coll_status;

    // Reference model state
    logic [PW-1:0]   m_vga;
    logic [1:0]      m_id;
    logic            m_valid, m_cvalid, m_ovr;
    logic [N-1:0]    m_acc, m_status;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sprite_compositor #(.NUM_SPR(N), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .data_enable(data_enable),
        .frame(frame), .spr_draw(spr_draw), .spr_pixel(spr_pixel),
        .spr_en(spr_en), .bg_color(bg_color), .vga_out(vga_out),
        .win_id(win_id), .win_valid(win_valid), .coll_status(coll_status),
        .coll_valid(coll_valid), .coll_ack(coll_ack), .coll_overrun(coll_overrun)
    );

    // Advance one clock: evaluate the model on the current inputs, then sample #1 after the edge.
    task automatic tick();
        logic [N-1:0]  req, contrib;
        logic [PW-1:0] n_vga;
        logic [1:0]    n_id;
        logic          n_valid, n_cvalid, n_ovr;
        logic [N-1:0]  n_acc, n_status;
        int            k;
        req = spr_draw & spr_en;
        n_vga = m_vga; n_id = m_id; n_valid = m_valid;
        n_acc = m_acc; n_status = m_status; n_cvalid = m_cvalid; n_ovr = m_ovr;
        if (rst) begin
            n_vga = 0; n_id = 0; n_valid = 0; n_acc = 0; n_status = 0; n_cvalid = 0; n_ovr = 0;
        end else if (pix_en) begin
            if (!data_enable) begin
                n_vga = 0; n_id = 0; n_valid = 0;
            end else if (req == 0) begin
                n_vga = bg_color; n_id = 0; n_valid = 0;
            end else begin
                k = -1;
                for (int i = 0; i < N; i++) if (req[i] && k < 0) k = i;
                n_vga = spr_pixel[k*PW +: PW]; n_id = k[1:0]; n_valid = 1;
            end
            contrib = (data_enable && $countones(req) >= 2) ? req : '0;
            if (frame) begin
                if (m_cvalid && !coll_ack) n_ovr = 1;
                n_status = m_acc | contrib; n_acc = 0; n_cvalid = 1;
            end else begin
                n_acc = m_acc | contrib;
                if (coll_ack) n_cvalid = 0;
            end
        end else if (coll_ack) begin
            n_cvalid = 0;
        end
        @(posedge clk);
        m_vga = n_vga; m_id = n_id; m_valid = n_valid;
        m_acc = n_acc; m_status = n_status; m_cvalid = n_cvalid; m_ovr = n_ovr;
        #1;
    endtask

    task automatic set_idle();
        rst = 0; pix_en = 1; data_enable = 1; frame = 0; coll_ack = 0;
        spr_draw = '0; spr_en = '1; bg_color = 8'h00;
    endtask

    task automatic pulse_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1; spr_draw = 4'hF; frame = 1; coll_ack = 1;
        tick(); tick();
        n_cmp++; if (vga_out !== 8'h00) begin n_fail++; $display("FAIL reset_vga: got %h expected 00", vga_out); end
        n_cmp++; if (win_id !== 2'd0) begin n_fail++; $display("FAIL reset_win_id: got %0d expected 0", win_id); end
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL reset_win_valid: got %b expected 0", win_valid); end
        n_cmp++; if (coll_status !== 4'h0) begin n_fail++; $display("FAIL reset_coll_status: got %h expected 0", coll_status); end
        n_cmp++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL reset_coll_valid: got %b expected 0", coll_valid); end
        n_cmp++; if (coll_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", coll_overrun); end
        set_idle();
    endtask

    task automatic test_priority();
        set_idle();
        spr_pixel = {$urandom, $urandom};
        spr_pixel[1*PW +: PW] = 8'hE0;
        spr_pixel[3*PW +: PW] = 8'h03;
        spr_draw = 4'b1010;
        tick();
        n_cmp++; if (vga_out !== 8'hE0) begin n_fail++; $display("FAIL prio_vga: got %h expected e0", vga_out); end
        n_cmp++; if (win_id !== 2'd1) begin n_fail++; $display("FAIL prio_win_id: got %0d expected 1", win_id); end
        n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("FAIL prio_win_valid: got %b expected 1", win_valid); end
    endtask

    task automatic test_background();
        set_idle();
        bg_color = 8'h12;
        tick();
        n_cmp++; if (vga_out !== 8'h12) begin n_fail++; $display("FAIL bg_vga: got %h expected 12", vga_out); end
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL bg_win_valid: got %b expected 0", win_valid); end
        data_enable = 0; spr_draw = 4'hF;
        tick();
        n_cmp++; if (vga_out !== 8'h00) begin n_fail++; $display("FAIL blank_vga: got %h expected 00", vga_out); end
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL blank_win_valid: got %b expected 0", win_valid); end
        n_cmp++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL blank_coll_valid: got %b expected 0", coll_valid); end
    endtask

    task automatic test_enable_mask();
        set_idle();
        spr_pixel = {$urandom, $urandom};
        spr_pixel[1*PW +: PW] = 8'h5A;
        spr_draw = 4'b0011; spr_en = 4'b1110;
        tick();
        n_cmp++; if (vga_out !== 8'h5A) begin n_fail++; $display("FAIL mask_vga: got %h expected 5a", vga_out); end
        n_cmp++; if (win_id !== 2'd1) begin n_fail++; $display("FAIL mask_win_id: got %0d expected 1", win_id); end
        // Clock enable low: everything holds even with a frame pulse present.
        pix_en = 0;
        for (int c = 0; c < 3; c++) begin
            spr_draw = 4'($urandom); spr_en = 4'hF; bg_color = 8'($urandom);
            spr_pixel = {$urandom, $urandom}; data_enable = 1'($urandom); frame = 1;
            tick();
            n_cmp++; if (vga_out !== 8'h5A) begin n_fail++; $display("FAIL hold_vga: got %h expected 5a", vga_out); end
            n_cmp++; if (win_id !== 2'd1 || win_valid !== 1'b1) begin n_fail++; $display("FAIL hold_win: got %0d/%b expected 1/1", win_id, win_valid); end
            n_cmp++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL hold_coll_valid: got %b expected 0", coll_valid); end
        end
        set_idle();
    endtask

    task automatic test_collision();
        set_idle(); pulse_reset();
        spr_draw = 4'b0101;
        repeat (5) tick();
        spr_draw = 4'b0000; frame = 1; tick(); frame = 0;
        n_cmp++; if (coll_status !== 4'b0101) begin n_fail++; $display("FAIL coll_status: got %b expected 0101", coll_status); end
        n_cmp++; if (coll_valid !== 1'b1) begin n_fail++; $display("FAIL coll_valid: got %b expected 1", coll_valid); end
        coll_ack = 1; tick(); coll_ack = 0;
        n_cmp++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b expected 0", coll_valid); end
        n_cmp++; if (coll_status !== 4'b0101) begin n_fail++; $display("FAIL ack_hold_status: got %b expected 0101", coll_status); end
        // Single sprites in video and an overlap during blanking must not count.
        spr_draw = 4'b0001; repeat (3) tick();
        data_enable = 0; spr_draw = 4'b1010; tick();
        data_enable = 1; spr_draw = 4'b0000; frame = 1; tick(); frame = 0;
        n_cmp++; if (coll_status !== 4'b0000) begin n_fail++; $display("FAIL coll_clean: got %b expected 0000", coll_status); end
        n_cmp++; if (coll_valid !== 1'b1 || coll_overrun !== 1'b0) begin n_fail++; $display("FAIL coll_clean_hs: got %b/%b expected 1/0", coll_valid, coll_overrun); end
    endtask

    task automatic test_handshake();
        set_idle(); pulse_reset();
        frame = 1; tick();
        n_cmp++; if (coll_valid !== 1'b1 || coll_overrun !== 1'b0) begin n_fail++; $display("FAIL hs_first: got %b/%b expected 1/0", coll_valid, coll_overrun); end
        tick(); frame = 0;
        n_cmp++; if (coll_overrun !== 1'b1) begin n_fail++; $display("FAIL hs_overrun: got %b expected 1", coll_overrun); end
        pulse_reset();
        frame = 1; tick(); frame = 0;
        pix_en = 0; coll_ack = 1; tick(); coll_ack = 0; pix_en = 1;
        n_cmp++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL hs_ack_no_pixen: got %b expected 0", coll_valid); end
        coll_ack = 1; tick(); coll_ack = 0;
        n_cmp++; if (coll_valid !== 1'b0) begin n_fail++; $display("FAIL hs_ack_idle: got %b expected 0", coll_valid); end
        frame = 1; tick();
        coll_ack = 1; tick(); frame = 0; coll_ack = 0;
        n_cmp++; if (coll_valid !== 1'b1) begin n_fail++; $display("FAIL hs_frame_ack_valid: got %b expected 1", coll_valid); end
        n_cmp++; if (coll_overrun !== 1'b0) begin n_fail++; $display("FAIL hs_frame_ack_overrun: got %b expected 0", coll_overrun); end
    endtask

    task automatic test_reset_midframe();
        set_idle(); pulse_reset();
        spr_pixel = {$urandom, $urandom};
        spr_draw = 4'b0011; repeat (3) tick();
        rst = 1; tick(); rst = 0;
        n_cmp++; if (vga_out !== 8'h00 || win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_vga: got %h/%b expected 00/0", vga_out, win_valid); end
        spr_draw = 4'b0000; frame = 1; tick(); frame = 0;
        n_cmp++; if (coll_status !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_status: got %b expected 0000", coll_status); end
        n_cmp++; if (coll_valid !== 1'b1) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 1", coll_valid); end
    endtask

    task automatic test_random();
        set_idle(); pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 299) == 0);
            pix_en      = ($urandom_range(0, 3) != 0);
            data_enable = ($urandom_range(0, 4) != 0);
            frame       = ($urandom_range(0, 24) == 0);
            coll_ack    = ($urandom_range(0, 5) == 0);
            spr_draw    = 4'($urandom);
            spr_en      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            spr_pixel   = {$urandom, $urandom};
            bg_color    = 8'($urandom);
            tick();
            n_cmp++; if (vga_out !== m_vga) begin n_fail++; $display("FAIL rnd_vga cyc %0d: got %h expected %h", c, vga_out, m_vga); end
            n_cmp++; if (win_id !== m_id) begin n_fail++; $display("FAIL rnd_win_id cyc %0d: got %0d expected %0d", c, win_id, m_id); end
            n_cmp++; if (win_valid !== m_valid) begin n_fail++; $display("FAIL rnd_win_valid cyc %0d: got %b expected %b", c, win_valid, m_valid); end
            n_cmp++; if (coll_status !== m_status) begin n_fail++; $display("FAIL rnd_coll_status cyc %0d: got %b expected %b", c, coll_status, m_status); end
            n_cmp++; if (coll_valid !== m_cvalid) begin n_fail++; $display("FAIL rnd_coll_valid cyc %0d: got %b expected %b", c, coll_valid, m_cvalid); end
            n_cmp++; if (coll_overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_overrun cyc %0d: got %b expected %b", c, coll_overrun, m_ovr); end
        end
        set_idle();
    endtask

    initial begin
        m_vga = 0; m_id = 0; m_valid = 0; m_acc = 0; m_status = 0; m_cvalid = 0; m_ovr = 0;
        spr_pixel = '0;
        set_idle();
        test_reset();
        test_priority();
        test_background();
        test_enable_mask();
        test_collision();
        test_handshake();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
